// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the button/DIP conditioner.
// hold_state_t : press-and-hold FSM encoding
// DEF_*        : default timing for a 50 MHz sys_clk
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2,
    REPEAT  = 2'd3
  } hold_state_t;

  localparam int unsigned DEF_DEB_W           = 20;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;  // 20 ms
  localparam int unsigned DEF_HOLD_W          = 26;
  localparam int unsigned DEF_LONG_CYCLES     = 50000000; // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 10000000; // 200 ms

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, counter debounce, rise/fall
// strobes and press-and-hold FSM with long-press and auto-repeat strobes.
// Ports:
//   sys_clk, reset : clock, async active-high reset
//   btn_raw        : raw pin level (1 = pressed)
//   repeat_en      : auto-repeat enable (sync to sys_clk)
//   btn_level      : debounced level
//   btn_rise/fall  : 1-cycle strobes on accepted press/release
//   long_press     : 1-cycle strobe when hold reaches LONG_CYCLES
//   btn_repeat     : 1-cycle auto-repeat strobe
//   btn_event      : btn_rise | btn_repeat
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEB_W           = DEF_DEB_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_W          = DEF_HOLD_W,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic long_press,
  output logic btn_repeat,
  output logic btn_event
);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  logic              s1, s2;
  logic [DEB_W-1:0]  deb_cnt;
  logic              accept, rise_next, fall_next;

  hold_state_t       state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              long_next, repeat_next;

  // Level change is accepted on the terminal debounce count.
  assign accept    = (s2 != btn_level) && (deb_cnt == DEB_LAST);
  assign rise_next = accept && s2;
  assign fall_next = accept && !s2;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      deb_cnt   <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if (s2 == btn_level || accept)
        deb_cnt <= '0;
      else
        deb_cnt <= deb_cnt + DEB_W'(1);
      if (accept)
        btn_level <= s2;
      btn_rise <= rise_next;
      btn_fall <= fall_next;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      long_press <= 1'b0;
      btn_repeat <= 1'b0;
      btn_event  <= 1'b0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_next;
      long_press <= long_next;
      btn_repeat <= repeat_next;
      btn_event  <= rise_next | repeat_next;
    end
  end

  // IDLE leaves on the registered level, so PRESSED starts the cycle after
  // btn_rise. Release is decoded from the accept itself so it lands with
  // btn_fall and overrides any coincident terminal count.
  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    if (fall_next) begin
      state_next = IDLE;
      hold_next  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (btn_level) begin
            state_next = PRESSED;
            hold_next  = '0;
          end
        end
        PRESSED: begin
          if (hold_cnt == LONG_LAST) begin
            long_next  = 1'b1;
            hold_next  = '0;
            state_next = repeat_en ? REPEAT : LONG;
          end else begin
            hold_next = hold_cnt + HOLD_W'(1);
          end
        end
        LONG: begin
        end
        REPEAT: begin
          if (!repeat_en) begin
            state_next = LONG;
          end else if (hold_cnt == REP_LAST) begin
            repeat_next = 1'b1;
            hold_next   = '0;
          end else begin
            hold_next = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          hold_next  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_debounce_array.sv
// NUM_CH independent button/DIP conditioners between the board pins and
// core logic. Each bit of every bus belongs to one channel.
// Ports:
//   sys_clk, reset : clock, async active-high reset
//   btn_raw        : raw pin levels (1 = pressed)
//   repeat_en      : per-channel auto-repeat enable
//   btn_level      : debounced levels
//   btn_rise/fall  : accepted press/release strobes
//   long_press     : long-hold strobes
//   btn_repeat     : auto-repeat strobes
//   btn_event      : btn_rise | btn_repeat
module btn_debounce_array
  import btn_debounce_pkg::*;
#(
  parameter int unsigned NUM_CH          = 5,
  parameter int unsigned DEB_W           = DEF_DEB_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_W          = DEF_HOLD_W,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_raw,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_rise,
  output logic [NUM_CH-1:0] btn_fall,
  output logic [NUM_CH-1:0] long_press,
  output logic [NUM_CH-1:0] btn_repeat,
  output logic [NUM_CH-1:0] btn_event
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_W           (DEB_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_W          (HOLD_W),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .repeat_en  (repeat_en[i]),
      .btn_level  (btn_level[i]),
      .btn_rise   (btn_rise[i]),
      .btn_fall   (btn_fall[i]),
      .long_press (long_press[i]),
      .btn_repeat (btn_repeat[i]),
      .btn_event  (btn_event[i])
    );
  end

endmodule
